reg_chain_pipe: RTL

Parametrised elastic register chain: a DEPTH-stage, WIDTH-bit pipeline with per-stage valid bits, a valid/ready handshake at both ends, optional per-stage data transform, flush, and transfer/occupancy counters. It is the generalised replacement for the fixed switch-to-LED register chain in soc_mini_top. Input is driven from the switch path, output feeds the LED path, and the whole chain can absorb backpressure without losing data.

---
 rtl/reg_chain_pipe.sv | 91 +++++++++
 1 files changed

// File: rtl/reg_chain_pipe.sv
// Elastic DEPTH-stage register chain with valid/ready handshakes at both ends,
// an optional per-stage data transform, flush, and occupancy/transfer counters.
module reg_chain_pipe #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int MODE  = 0,
   parameter int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   output logic [OCC_W-1:0] occupancy,
   output logic [31:0]      xfer_count
);

   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] d [DEPTH];
   logic [DEPTH:0]   r;
   logic [DEPTH-1:0] src_v;
   logic [WIDTH-1:0] src_d [DEPTH];

   function automatic logic [WIDTH-1:0] xform(input logic [WIDTH-1:0] x);
      case (MODE)
         1:       return x + WIDTH'(1);
         2:       return (x << 1) | (x >> (WIDTH - 1));
         default: return x;
      endcase
   endfunction

   // A stage can take a new word when it is empty or its successor is draining.
   always_comb begin
      r[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         r[i] = !v[i] | r[i+1];
      end
   end

   always_comb begin
      src_v[0] = in_valid;
      src_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         src_v[i] = v[i-1];
         src_d[i] = d[i-1];
      end
   end

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupancy = occupancy + OCC_W'(v[i]);
      end
   end

   assign in_ready  = r[0] & !flush & !reset;
   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];

   // Flush only clears the valid bits; data registers keep their last contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v          <= '0;
         xfer_count <= 32'd0;
         for (int i = 0; i < DEPTH; i++) begin
            d[i] <= '0;
         end
      end else begin
         if (flush) begin
            v <= '0;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (r[i]) begin
                  v[i] <= src_v[i];
                  if (src_v[i]) begin
                     d[i] <= xform(src_d[i]);
                  end
               end
            end
         end
         if (out_valid && out_ready) begin
            xfer_count <= xfer_count + 32'd1;
         end
      end
   end

endmodule
